// File: rtl/bool_issue_scheduler.sv
// Issue scheduler for the 3-lane parallel-bool encoder.
// Packs bools into slots, tracks them through the encoder, flags end of stream.
module bool_issue_scheduler #(
    parameter int RANGE_WIDTH  = 16,
    parameter int SYMBOL_WIDTH = 4,
    parameter int PIPE_DEPTH   = 3,
    parameter int TIMEOUT      = 8,
    parameter int TO_WIDTH     = 4
) (
    input  logic                    general_clk,
    input  logic                    reset,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [RANGE_WIDTH-1:0]  in_fl,
    input  logic [RANGE_WIDTH-1:0]  in_fh,
    input  logic [SYMBOL_WIDTH-1:0] in_symbol,
    input  logic [SYMBOL_WIDTH:0]   in_nsyms,
    input  logic                    in_bool,
    input  logic                    in_last,
    output logic                    enc_valid,
    output logic [1:0]              enc_lanes,
    output logic [RANGE_WIDTH-1:0]  enc_fl,
    output logic [RANGE_WIDTH-1:0]  enc_fh,
    output logic [SYMBOL_WIDTH:0]   enc_nsyms,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_1,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_2,
    output logic [SYMBOL_WIDTH-1:0] enc_symbol_3,
    output logic                    enc_bool_1,
    output logic                    enc_bool_2,
    output logic                    enc_bool_3,
    output logic                    res_valid,
    output logic [1:0]              res_lanes,
    output logic                    done,
    output logic                    busy
);

    typedef enum logic [1:0] {S_IDLE, S_ACC, S_DRAIN} state_e;

    state_e                  state_q, state_d;
    logic [1:0]              pending_q, pending_d;
    logic [SYMBOL_WIDTH-1:0] hold1_q, hold1_d, hold2_q, hold2_d;
    logic [TO_WIDTH-1:0]     to_q, to_d;
    logic                    enc_valid_q, enc_valid_d;
    logic [1:0]              enc_lanes_q, enc_lanes_d;
    logic [RANGE_WIDTH-1:0]  enc_fl_q, enc_fl_d, enc_fh_q, enc_fh_d;
    logic [SYMBOL_WIDTH:0]   enc_nsyms_q, enc_nsyms_d;
    logic [SYMBOL_WIDTH-1:0] sym1_q, sym1_d, sym2_q, sym2_d, sym3_q, sym3_d;
    logic                    b1_q, b1_d, b2_q, b2_d, b3_q, b3_d;
    logic                    enc_last_q, enc_last_d;
    logic [PIPE_DEPTH-1:0]   pv_q, pv_d, pt_q, pt_d;
    logic [PIPE_DEPTH-1:0][1:0] pl_q, pl_d;
    logic                    accept;
    logic [1:0]              p_inc;

    assign in_ready = (state_q != S_DRAIN) &&
                      !(state_q == S_ACC && in_valid && !in_bool);
    assign accept   = in_valid && in_ready;
    assign p_inc    = pending_q + 2'd1;

    always_comb begin
        state_d     = state_q;
        pending_d   = pending_q;
        hold1_d     = hold1_q;
        hold2_d     = hold2_q;
        to_d        = to_q;
        enc_valid_d = 1'b0;
        enc_lanes_d = enc_lanes_q;
        enc_fl_d    = enc_fl_q;
        enc_fh_d    = enc_fh_q;
        enc_nsyms_d = enc_nsyms_q;
        sym1_d      = sym1_q;
        sym2_d      = sym2_q;
        sym3_d      = sym3_q;
        b1_d        = b1_q;
        b2_d        = b2_q;
        b3_d        = b3_q;
        enc_last_d  = enc_last_q;
        if (state_q == S_DRAIN) begin
            if (done) state_d = S_IDLE;
        end else if (accept && in_bool) begin
            to_d = '0;
            if (p_inc == 2'd3 || in_last) begin
                enc_valid_d = 1'b1;
                enc_lanes_d = p_inc;
                enc_fl_d    = '0;
                enc_fh_d    = '0;
                enc_nsyms_d = '0;
                sym1_d      = (p_inc == 2'd1) ? in_symbol : hold1_q;
                sym2_d      = (p_inc == 2'd2) ? in_symbol :
                              (p_inc == 2'd3) ? hold2_q : '0;
                sym3_d      = (p_inc == 2'd3) ? in_symbol : '0;
                b1_d        = 1'b1;
                b2_d        = (p_inc != 2'd1);
                b3_d        = (p_inc == 2'd3);
                enc_last_d  = in_last;
                pending_d   = '0;
                state_d     = in_last ? S_DRAIN : S_IDLE;
            end else begin
                if (pending_q == 2'd0) hold1_d = in_symbol;
                else                   hold2_d = in_symbol;
                pending_d = p_inc;
                state_d   = S_ACC;
            end
        end else if (accept) begin
            enc_valid_d = 1'b1;
            enc_lanes_d = 2'd1;
            enc_fl_d    = in_fl;
            enc_fh_d    = in_fh;
            enc_nsyms_d = in_nsyms;
            sym1_d      = in_symbol;
            sym2_d      = '0;
            sym3_d      = '0;
            b1_d        = 1'b0;
            b2_d        = 1'b0;
            b3_d        = 1'b0;
            enc_last_d  = in_last;
            to_d        = '0;
            state_d     = in_last ? S_DRAIN : S_IDLE;
        end else if (state_q == S_ACC &&
                     (in_valid || to_q == TO_WIDTH'(TIMEOUT))) begin
            // refused non-bool or idle timeout: flush held bools
            enc_valid_d = 1'b1;
            enc_lanes_d = pending_q;
            enc_fl_d    = '0;
            enc_fh_d    = '0;
            enc_nsyms_d = '0;
            sym1_d      = hold1_q;
            sym2_d      = (pending_q == 2'd2) ? hold2_q : '0;
            sym3_d      = '0;
            b1_d        = 1'b1;
            b2_d        = (pending_q == 2'd2);
            b3_d        = 1'b0;
            enc_last_d  = 1'b0;
            pending_d   = '0;
            to_d        = '0;
            state_d     = S_IDLE;
        end else if (state_q == S_ACC) begin
            to_d = to_q + TO_WIDTH'(1);
        end
    end

    always_comb begin
        pv_d    = '0;
        pt_d    = '0;
        pl_d    = '0;
        pv_d[0] = enc_valid_q;
        pt_d[0] = enc_valid_q && enc_last_q;
        pl_d[0] = enc_lanes_q;
        for (int i = 1; i < PIPE_DEPTH; i++) begin
            pv_d[i] = pv_q[i-1];
            pt_d[i] = pt_q[i-1];
            pl_d[i] = pl_q[i-1];
        end
    end

    always_ff @(posedge general_clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            pending_q   <= '0;
            hold1_q     <= '0;
            hold2_q     <= '0;
            to_q        <= '0;
            enc_valid_q <= 1'b0;
            enc_lanes_q <= '0;
            enc_fl_q    <= '0;
            enc_fh_q    <= '0;
            enc_nsyms_q <= '0;
            sym1_q      <= '0;
            sym2_q      <= '0;
            sym3_q      <= '0;
            b1_q        <= 1'b0;
            b2_q        <= 1'b0;
            b3_q        <= 1'b0;
            enc_last_q  <= 1'b0;
            pv_q        <= '0;
            pt_q        <= '0;
            pl_q        <= '0;
        end else begin
            state_q     <= state_d;
            pending_q   <= pending_d;
            hold1_q     <= hold1_d;
            hold2_q     <= hold2_d;
            to_q        <= to_d;
            enc_valid_q <= enc_valid_d;
            enc_lanes_q <= enc_lanes_d;
            enc_fl_q    <= enc_fl_d;
            enc_fh_q    <= enc_fh_d;
            enc_nsyms_q <= enc_nsyms_d;
            sym1_q      <= sym1_d;
            sym2_q      <= sym2_d;
            sym3_q      <= sym3_d;
            b1_q        <= b1_d;
            b2_q        <= b2_d;
            b3_q        <= b3_d;
            enc_last_q  <= enc_last_d;
            pv_q        <= pv_d;
            pt_q        <= pt_d;
            pl_q        <= pl_d;
        end
    end

    assign enc_valid    = enc_valid_q;
    assign enc_lanes    = enc_lanes_q;
    assign enc_fl       = enc_fl_q;
    assign enc_fh       = enc_fh_q;
    assign enc_nsyms    = enc_nsyms_q;
    assign enc_symbol_1 = sym1_q;
    assign enc_symbol_2 = sym2_q;
    assign enc_symbol_3 = sym3_q;
    assign enc_bool_1   = b1_q;
    assign enc_bool_2   = b2_q;
    assign enc_bool_3   = b3_q;
    assign res_valid    = pv_q[PIPE_DEPTH-1];
    assign res_lanes    = pl_q[PIPE_DEPTH-1];
    assign done         = pv_q[PIPE_DEPTH-1] && pt_q[PIPE_DEPTH-1];
    assign busy         = (state_q != S_IDLE);

endmodule

// File: tb/tb_bool_issue_scheduler.sv
// Directed self-checking bench for bool_issue_scheduler.
// Each task drives one scenario and compares against hand-derived values.
module tb_bool_issue_scheduler;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid, in_ready, in_bool, in_last;
    logic [15:0] in_fl, in_fh;
    logic [3:0]  in_symbol;
    logic [4:0]  in_nsyms;
    logic        enc_valid;
    logic [1:0]  enc_lanes;
    logic [15:0] enc_fl, enc_fh;
    logic [4:0]  enc_nsyms;
    logic [3:0]  s1, s2, s3;
    logic        b1, b2, b3;
    logic        res_valid;
    logic [1:0]  res_lanes;
    logic        done, busy;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    bool_issue_scheduler dut (
        .general_clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_fl(in_fl), .in_fh(in_fh), .in_symbol(in_symbol),
        .in_nsyms(in_nsyms), .in_bool(in_bool), .in_last(in_last),
        .enc_valid(enc_valid), .enc_lanes(enc_lanes),
        .enc_fl(enc_fl), .enc_fh(enc_fh), .enc_nsyms(enc_nsyms),
        .enc_symbol_1(s1), .enc_symbol_2(s2), .enc_symbol_3(s3),
        .enc_bool_1(b1), .enc_bool_2(b2), .enc_bool_3(b3),
        .res_valid(res_valid), .res_lanes(res_lanes),
        .done(done), .busy(busy)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic b, input logic l,
                         input logic [3:0] s, input logic [15:0] fl,
                         input logic [15:0] fh, input logic [4:0] ns);
        in_valid  = v;
        in_bool   = b;
        in_last   = l;
        in_symbol = s;
        in_fl     = fl;
        in_fh     = fh;
        in_nsyms  = ns;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(0, 0, 0, 0, 0, 0, 0);
        #3;
        tests++;
        if ({enc_valid, busy, res_valid, done, enc_lanes, enc_fl} !== '0) begin
            fails++;
            $display("FAIL reset_outputs got %0h exp 0",
                     {enc_valid, busy, res_valid, done, enc_lanes, enc_fl});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        #1;
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL reset_ready got %0b exp 1", in_ready);
        end
        drive(1, 0, 0, 4'd3, 16'd55, 16'd77, 5'd6);
        tick();
        drive(1, 1, 0, 4'd1, 0, 0, 0);
        tick();
        tests++;
        if (busy !== 1'b1 || enc_fl !== 16'd55) begin
            fails++;
            $display("FAIL pre_reset got busy=%0b fl=%0d exp 1/55", busy, enc_fl);
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        #2 reset = 1'b1;
        #1;
        tests++;
        if ({busy, enc_valid, enc_fl, res_valid} !== '0) begin
            fails++;
            $display("FAIL async_reset got %0h exp 0",
                     {busy, enc_valid, enc_fl, res_valid});
        end
        @(posedge clk);
        #1 reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            tick();
            tests++;
            if (res_valid !== 1'b0 || enc_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_discard got res=%0b enc=%0b exp 0/0",
                         res_valid, enc_valid);
            end
        end
        tests++;
        if (in_ready !== 1'b1 || busy !== 1'b0) begin
            fails++;
            $display("FAIL post_reset got rdy=%0b busy=%0b exp 1/0", in_ready, busy);
        end
    endtask

    task automatic test_bool_pack();
        drive(1, 1, 0, 4'd1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 4'd0, 0, 0, 0);
        tick();
        tests++;
        if (enc_valid !== 1'b0 || busy !== 1'b1) begin
            fails++;
            $display("FAIL pack_hold got enc=%0b busy=%0b exp 0/1", enc_valid, busy);
        end
        drive(1, 1, 0, 4'd1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++;
        if ({enc_valid, enc_lanes, s1, s2, s3, b1, b2, b3, enc_fl} !==
            {1'b1, 2'd3, 4'd1, 4'd0, 4'd1, 3'b111, 16'd0}) begin
            fails++;
            $display("FAIL pack_slot got v=%0b l=%0d s=%0d%0d%0d b=%0b%0b%0b exp 1 3 101 111",
                     enc_valid, enc_lanes, s1, s2, s3, b1, b2, b3);
        end
        for (int i = 1; i <= 4; i++) begin
            tick();
            tests++;
            if (res_valid !== (i == 3) || done !== 1'b0) begin
                fails++;
                $display("FAIL pack_res_%0d got %0b exp %0b", i, res_valid, i == 3);
            end
            if (i == 3) begin
                tests++;
                if (res_lanes !== 2'd3) begin
                    fails++;
                    $display("FAIL pack_res_lanes got %0d exp 3", res_lanes);
                end
            end
        end
    endtask

    task automatic test_break();
        drive(1, 1, 0, 4'd1, 0, 0, 0);
        tick();
        drive(1, 0, 0, 4'd2, 16'd100, 16'd200, 5'd4);
        #1;
        tests++;
        if (in_ready !== 1'b0) begin
            fails++;
            $display("FAIL break_refuse got %0b exp 0", in_ready);
        end
        tick();
        tests++;
        if ({enc_valid, enc_lanes, b1, b2, s1} !== {1'b1, 2'd1, 1'b1, 1'b0, 4'd1}) begin
            fails++;
            $display("FAIL break_partial got v=%0b l=%0d b1=%0b s1=%0d exp 1 1 1 1",
                     enc_valid, enc_lanes, b1, s1);
        end
        tests++;
        if (in_ready !== 1'b1) begin
            fails++;
            $display("FAIL break_ready got %0b exp 1", in_ready);
        end
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++;
        if ({enc_valid, enc_lanes, b1, enc_fl, enc_fh, enc_nsyms, s1} !==
            {1'b1, 2'd1, 1'b0, 16'd100, 16'd200, 5'd4, 4'd2}) begin
            fails++;
            $display("FAIL break_cdf got v=%0b l=%0d b1=%0b fl=%0d fh=%0d ns=%0d s1=%0d",
                     enc_valid, enc_lanes, b1, enc_fl, enc_fh, enc_nsyms, s1);
        end
        repeat (5) tick();
    endtask

    task automatic test_timeout();
        drive(1, 1, 0, 4'd1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 4'd0, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        for (int i = 0; i < 8; i++) begin
            tick();
            tests++;
            if (enc_valid !== 1'b0) begin
                fails++;
                $display("FAIL timeout_early_%0d got 1 exp 0", i);
            end
        end
        tick();
        tests++;
        if ({enc_valid, enc_lanes, s1, s2, b1, b2, b3, busy} !==
            {1'b1, 2'd2, 4'd1, 4'd0, 3'b110, 1'b0}) begin
            fails++;
            $display("FAIL timeout_issue got v=%0b l=%0d s=%0d%0d b=%0b%0b%0b busy=%0b",
                     enc_valid, enc_lanes, s1, s2, b1, b2, b3, busy);
        end
        repeat (5) tick();
    endtask

    task automatic test_stream_end();
        drive(1, 1, 0, 4'd1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 4'd1, 0, 0, 0);
        tick();
        drive(1, 1, 0, 4'd0, 0, 0, 0);
        tick();
        tests++;
        if (enc_valid !== 1'b1 || enc_lanes !== 2'd3) begin
            fails++;
            $display("FAIL eos_first got v=%0b l=%0d exp 1 3", enc_valid, enc_lanes);
        end
        drive(1, 1, 1, 4'd1, 0, 0, 0);
        tick();
        drive(0, 0, 0, 0, 0, 0, 0);
        tests++;
        if ({enc_valid, enc_lanes, s1, b2, busy, in_ready} !==
            {1'b1, 2'd1, 4'd1, 1'b0, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL eos_last got v=%0b l=%0d s1=%0d b2=%0b busy=%0b rdy=%0b",
                     enc_valid, enc_lanes, s1, b2, busy, in_ready);
        end
        tick();
        tick();
        tests++;
        if ({res_valid, res_lanes, done, in_ready} !== {1'b1, 2'd3, 1'b0, 1'b0}) begin
            fails++;
            $display("FAIL eos_res3 got v=%0b l=%0d done=%0b rdy=%0b exp 1 3 0 0",
                     res_valid, res_lanes, done, in_ready);
        end
        tick();
        tests++;
        if ({res_valid, res_lanes, done, in_ready} !== {1'b1, 2'd1, 1'b1, 1'b0}) begin
            fails++;
            $display("FAIL eos_done got v=%0b l=%0d done=%0b rdy=%0b exp 1 1 1 0",
                     res_valid, res_lanes, done, in_ready);
        end
        tick();
        tests++;
        if ({done, in_ready, busy} !== 3'b010) begin
            fails++;
            $display("FAIL eos_idle got done=%0b rdy=%0b busy=%0b exp 0 1 0",
                     done, in_ready, busy);
        end
    endtask

    task automatic test_back_to_back();
        for (int i = 1; i <= 5; i++) begin
            drive(1, 0, 0, 4'(i), 16'(10 * i), 16'(10 * i + 5), 5'd8);
            #1;
            tests++;
            if (in_ready !== 1'b1) begin
                fails++;
                $display("FAIL b2b_ready_%0d got 0 exp 1", i);
            end
            tick();
            tests++;
            if (enc_valid !== 1'b1 || enc_fl !== 16'(10 * i) || s1 !== 4'(i)) begin
                fails++;
                $display("FAIL b2b_issue_%0d got v=%0b fl=%0d s1=%0d exp 1 %0d %0d",
                         i, enc_valid, enc_fl, s1, 10 * i, i);
            end
        end
        drive(0, 0, 0, 0, 0, 0, 0);
        tick();
        tests++;
        if (enc_valid !== 1'b0 || enc_fl !== 16'd50 || enc_fh !== 16'd55) begin
            fails++;
            $display("FAIL b2b_hold got v=%0b fl=%0d fh=%0d exp 0 50 55",
                     enc_valid, enc_fl, enc_fh);
        end
    endtask

    initial begin
        test_reset();
        test_bool_pack();
        test_break();
        test_timeout();
        test_stream_end();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
